// File: rtl/product_accumulator.sv
// product_accumulator: sums the 16-bit unsigned product beats of one frame
// into a saturating accumulator. When the last beat of a frame is accepted,
// the total, the beat count and an overflow flag are presented on a
// registered result port and held until the consumer takes them.
module product_accumulator #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_product,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    typedef enum logic {ACCUM = 1'b0, DONE = 1'b1} state_t;

    // Frame result as presented on the output port.
    typedef struct packed {
        logic [ACC_W-1:0] sum;
        logic [CNT_W-1:0] count;
        logic             ovf;
    } result_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    result_t          res;
    logic             res_vld;

    logic [ACC_W:0]   sum_wide;
    logic [ACC_W-1:0] acc_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             ovf_nxt;
    logic             accept;

    // Next accumulator values for a beat accepted this cycle. Once ovf is
    // set the sum is pinned at all ones for the rest of the frame.
    always_comb begin
        sum_wide = {1'b0, acc} + {{(ACC_W + 1 - 16){1'b0}}, in_product};
        ovf_nxt  = ovf | sum_wide[ACC_W];
        acc_nxt  = ovf_nxt ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
        cnt_nxt  = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
    end

    // in_ready depends on state only, so there is no combinational path
    // from in_valid or out_ready.
    assign in_ready = (state == ACCUM);
    assign accept   = in_valid & in_ready;

    // Frame FSM: accumulate in ACCUM, hold the result in DONE. clr aborts
    // everything, including a beat or a result handshake in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ACCUM;
            acc     <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            res     <= '0;
            res_vld <= 1'b0;
        end else if (clr) begin
            state   <= ACCUM;
            acc     <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            res_vld <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        acc <= acc_nxt;
                        cnt <= cnt_nxt;
                        ovf <= ovf_nxt;
                        if (in_last) begin
                            res     <= '{sum: acc_nxt, count: cnt_nxt, ovf: ovf_nxt};
                            res_vld <= 1'b1;
                            state   <= DONE;
                        end
                    end
                end
                DONE: begin
                    // Result registers keep their values after the handshake.
                    if (out_ready) begin
                        acc     <= '0;
                        cnt     <= '0;
                        ovf     <= 1'b0;
                        res_vld <= 1'b0;
                        state   <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

    assign out_valid = res_vld;
    assign out_sum   = res.sum;
    assign out_count = res.count;
    assign out_ovf   = res.ovf;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: framing, back-pressure,
// saturation, clr abort and asynchronous reset.
module tb_product_accumulator;

    localparam int ACC_W = 24;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             clr;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_product;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;

    int passed = 0;
    int total  = 0;

    product_accumulator #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_product (in_product),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_count  (out_count),
        .out_ovf    (out_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic beat(input logic [15:0] p, input logic last);
        in_valid   = 1'b1;
        in_product = p;
        in_last    = last;
        step();
        in_valid   = 1'b0;
        in_last    = 1'b0;
    endtask

    task automatic chk_result(input string tag, input logic [31:0] s,
                              input logic [31:0] c, input logic o);
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".ready"}, 32'(in_ready), 32'd0);
        chk({tag, ".sum"},   32'(out_sum), s);
        chk({tag, ".count"}, 32'(out_count), c);
        chk({tag, ".ovf"},   32'(out_ovf), 32'(o));
    endtask

    initial begin
        rst_n      = 1'b0;
        clr        = 1'b0;
        in_valid   = 1'b0;
        in_product = '0;
        in_last    = 1'b0;
        out_ready  = 1'b0;

        // ---- reset
        step(); step();
        rst_n = 1'b1;
        chk("rst.valid", 32'(out_valid), 32'd0);
        chk("rst.sum",   32'(out_sum), 32'd0);
        chk("rst.count", 32'(out_count), 32'd0);
        chk("rst.ovf",   32'(out_ovf), 32'd0);
        step();
        chk("rst.ready", 32'(in_ready), 32'd1);

        // ---- basic 3-beat frame, consumer always ready
        out_ready = 1'b1;
        beat(16'h0006, 1'b0);
        beat(16'h0023, 1'b0);
        beat(16'hFE01, 1'b1);
        chk_result("f3", 32'h00FE2A, 32'd3, 1'b0);
        step();
        chk("f3.ready_back", 32'(in_ready), 32'd1);
        chk("f3.valid_drop", 32'(out_valid), 32'd0);
        chk("f3.sum_kept",   32'(out_sum), 32'h00FE2A);

        // ---- back-pressure: result held 5 cycles with a beat waiting
        out_ready = 1'b0;
        beat(16'h0006, 1'b0);
        beat(16'h0023, 1'b0);
        beat(16'hFE01, 1'b1);
        in_valid   = 1'b1;
        in_product = 16'h0001;
        in_last    = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_result("bp.hold", 32'h00FE2A, 32'd3, 1'b0);
        end
        out_ready = 1'b1;
        step();
        chk("bp.ready_back", 32'(in_ready), 32'd1);
        step();                    // held 0x0001 accepted here
        beat(16'h0002, 1'b1);
        chk_result("bp.next", 32'd3, 32'd2, 1'b0);
        step();

        // ---- 256 beats of 0xFFFF: fits exactly, count saturates
        for (int i = 1; i <= 256; i++) beat(16'hFFFF, i == 256);
        chk_result("sat256", 32'hFFFF00, 32'd255, 1'b0);
        step();

        // ---- 257 beats of 0xFFFF: sum saturates
        for (int i = 1; i <= 257; i++) beat(16'hFFFF, i == 257);
        chk_result("sat257", 32'hFFFFFF, 32'd255, 1'b1);
        step();

        // ---- single zero beat: new frame starts with ovf clear
        beat(16'h0000, 1'b1);
        chk_result("single0", 32'd0, 32'd1, 1'b0);
        step();

        // ---- clr mid-frame discards the beat presented with it
        beat(16'h0010, 1'b0);
        beat(16'h0020, 1'b0);
        clr = 1'b1;
        chk("clr.ready_in_cycle", 32'(in_ready), 32'd1);
        beat(16'h0040, 1'b0);
        clr = 1'b0;
        beat(16'h0005, 1'b1);
        chk_result("clr.frame", 32'd5, 32'd1, 1'b0);
        step();

        // ---- clr in DONE wins over the result handshake
        beat(16'h0007, 1'b1);
        chk("clrdone.valid_pre", 32'(out_valid), 32'd1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clrdone.valid", 32'(out_valid), 32'd0);
        chk("clrdone.ready", 32'(in_ready), 32'd1);
        beat(16'h0003, 1'b1);
        chk_result("clrdone.next", 32'd3, 32'd1, 1'b0);
        step();

        // ---- asynchronous reset pulse while in DONE
        out_ready = 1'b0;
        beat(16'h0009, 1'b1);
        chk("arst.valid_pre", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.valid", 32'(out_valid), 32'd0);
        chk("arst.sum",   32'(out_sum), 32'd0);
        chk("arst.count", 32'(out_count), 32'd0);
        chk("arst.ovf",   32'(out_ovf), 32'd0);
        rst_n = 1'b1;
        step();
        out_ready = 1'b1;
        beat(16'h0004, 1'b0);
        beat(16'h0004, 1'b1);
        chk_result("arst.next", 32'd8, 32'd2, 1'b0);
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
# product_accumulator

Sequential accumulate stage directly downstream of the 8×8 combinational multiplier. It consumes the 16-bit unsigned product as a stream of beats under a valid/ready handshake and sums the beats of one frame into a saturating accumulator. The frame ends on the beat marked `in_last`; the block then presents the total and the beat count on a registered result port and holds them until the consumer accepts. Together with the multiplier it forms the datapath's dot-product / MAC path.

## Interface
- `ACC_W`, 24: accumulator and result width. Must be ≥ 17.
- `CNT_W`, 8: beat-counter width.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clr`  in  1  synchronous abort/clear. Highest priority below reset.
- `in_valid`  in  1  product beat valid.
- `in_ready`  out  1  block can accept a beat.
- `in_product`  in  16  unsigned product from the multiplier.
- `in_last`  in  1  marks the final beat of a frame.
- `out_valid`  out  1  result valid, registered.
- `out_ready`  in  1  consumer accepts the result.
- `out_sum`  out  ACC_W  frame total, saturated.
- `out_count`  out  CNT_W  beats accepted in the frame, saturated.
- `out_ovf`  out  1  the sum saturated during this frame.

## Operation
- Two states:
  - ACCUM (reset state): `in_ready`=1, `out_valid`=0.
  - DONE: `in_ready`=0, `out_valid`=1.
- Beat accept = `in_valid` & `in_ready`.
- On accept in ACCUM:
  - acc ← sat(acc + zero-extend(`in_product`)). The add is computed at ACC_W+1 bits.
  - If the carry-out is set, or `ovf` is already set: acc ← all ones, `ovf` ← 1.
  - cnt ← cnt+1, saturating at 2^CNT_W−1 (no wrap).
- Accept with `in_last`=1:
  - The updated acc/cnt/ovf are loaded into `out_sum`/`out_count`/`out_ovf`.
  - State → DONE.
- A single-beat frame (`in_last` on the first beat) is legal: count = 1.
- DONE:
  - Outputs stay stable until `out_ready`=1.
  - On that handshake: acc, cnt and ovf clear to 0; state → ACCUM.
  - `out_sum`/`out_count`/`out_ovf` keep their last values; only `out_valid` drops.
- `in_valid` without `in_last` simply continues the frame. There is no frame-length limit.
- `clr`=1 in any state:
  - acc, cnt, ovf → 0; state → ACCUM; `out_valid` → 0.
  - A beat presented in the same cycle is discarded, even though `in_ready` was 1.
  - Result registers are not required to clear.

## Timing
- Reset (asynchronous assert, synchronous release):
  - State ACCUM, acc=0, cnt=0, ovf=0.
  - `out_valid`=0, `out_sum`=0, `out_count`=0, `out_ovf`=0.
  - `in_ready`=1 from the first edge after release.
- `in_ready` is a decode of state only. It has no combinational path from `in_valid` or `out_ready`.
- Throughput: one beat per cycle in ACCUM.
- Latency: last beat accepted at edge N → `out_valid`=1 with the final values after edge N.
- Back-pressure: while in DONE, no beat is taken, `in_ready`=0 until the handshake edge.
- Result handshake at edge M → `in_ready`=1 after edge M. Minimum frame-to-frame bubble is 1 cycle (the DONE cycle) when `out_ready` is held high.
- `clr` together with the `out_ready` handshake: `clr` wins. The result counts as dropped.
- Reset asserted mid-frame or in DONE: all state is lost immediately; no partial result is emitted.

## Test plan
- Reset, then 3-beat frame 0x0006, 0x0023, 0xFE01 (last), `out_ready`=1 → one cycle after the last beat: `out_valid`=1, `out_sum`=0x00FE2A (65066), `out_count`=3, `out_ovf`=0; `in_ready` returns the next cycle.
- Back-pressure: same frame with `out_ready`=0 for 5 cycles, `in_valid` held high with beat 0x0001 → `in_ready`=0 and outputs stable for all 5 cycles. Beat 0x0001 is accepted only after the handshake and starts the new frame with acc=1.
- Saturation: 257 beats of 0xFFFF, last on beat 257 → after beat 256 acc=0xFFFF00. Result: `out_sum`=0xFFFFFF, `out_ovf`=1, `out_count`=255 (saturated). The next frame starts with `ovf`=0.
- Single beat 0x0000 with `in_last` → `out_sum`=0, `out_count`=1, `out_ovf`=0.
- `clr` mid-frame after beats 0x0010, 0x0020, with beat 0x0040 presented in the `clr` cycle → that beat is discarded. A following frame of 0x0005 (last) yields `out_sum`=5, `out_count`=1.
- Asynchronous `rst_n` pulse between clock edges while in DONE → `out_valid` drops immediately and all outputs read 0. After release the block accepts a new frame normally.
